fp_int_mul_vec: RTL and testbench
=================================

FP_INT_MUL_VEC -- requirements
Module: fp_int_mul_vec

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of parallel activation/weight lanes.
REQ-002 SHALL have parameter MAX_PREC, default 8 (legal 2..8), meaning the maximum weight bit-width.
REQ-003 SHALL have derived localparam MANT_W = 11+MAX_PREC, meaning the product magnitude width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 act  in  16*LANES  FP16 activation per lane; lane i is act[16i+15:16i].
REQ-007 w  in  LANES  one serial weight bit per lane, MSB first.
REQ-008 valid  in  1  weight bits on w are valid this cycle.
REQ-009 in_ready  out  1  the block accepts w this cycle.
REQ-010 precision  in  4  weight bit-width, latched at word start.
REQ-011 w_signed  in  1  two's-complement weight mode, latched at word start.
REQ-012 sign_out  out  LANES  product sign per lane.
REQ-013 exp_out  out  5*LANES  product exponent per lane.
REQ-014 mantissa_out  out  MANT_W*LANES  product magnitude per lane.
REQ-015 out_valid  out  1  result registers hold an unconsumed word.
REQ-016 out_ready  in  1  downstream accepts the result.

Function
REQ-017 A bit beat SHALL occur when valid && in_ready; no other cycle alters accumulator or counter.
REQ-018 FSM states: IDLE, SHIFT; IDLE->SHIFT on a beat; SHIFT->IDLE on the beat with count==prec-1.
REQ-019 On the first beat of a word, act, precision and w_signed SHALL be latched; later changes within the word are ignored.
REQ-020 Precision 0 or >MAX_PREC SHALL be treated as MAX_PREC; precision 1 SHALL complete in one beat.
REQ-021 Per lane, mant = {exp!=0, act[9:0]} (11 bits); per beat, acc <= (acc<<1) + (w ? mant : 0).
REQ-022 With signed mode active, the first beat SHALL use acc <= (w ? -mant : 0) instead.
REQ-023 valid low mid-word SHALL pause the word with count and acc held, with no timeout.
REQ-024 On the final beat, the result SHALL be written to the output registers, with out_valid high the next cycle (1-cycle latency from the last bit).
REQ-025 mantissa_out = |acc| truncated to MANT_W bits; sign_out = act sign XOR (acc<0); exp_out = act[14:10] unchanged, with no normalisation.
REQ-026 out_valid SHALL stay high, with outputs stable, until out_valid && out_ready; it then clears unless a new final beat lands the same cycle.
REQ-027 in_ready = !(out_valid && !out_ready) || state==SHIFT && count<prec-1, i.e. only the final beat stalls against a full output register.
REQ-028 A final beat with simultaneous drain (out_ready=1) SHALL be accepted, allowing back-to-back words with no bubble.
REQ-029 A new word's first beat MAY occur the cycle after the previous word's final beat.

Reset
REQ-030 On rst low, asynchronously: state=IDLE, count=0, acc=0, out_valid=0, sign_out=0, exp_out=0, mantissa_out=0.
REQ-031 Reset mid-word SHALL discard the partial word; the first beat after release SHALL start a new word.
REQ-032 in_ready SHALL be 1 while in reset and after release.

Configuration
REQ-033 The macro FP_INT_MUL_VEC_SIGNED_EN SHALL control signed-weight support.
REQ-034 With FP_INT_MUL_VEC_SIGNED_EN defined, w_signed=1 SHALL select two's-complement weights (REQ-022).
REQ-035 Without FP_INT_MUL_VEC_SIGNED_EN, w_signed SHALL be ignored and weights SHALL always be unsigned, with no subtract logic present.

Verification
REQ-036 Unsigned product: lane0 act=0x1234, precision=4, bits 0,1,0,1 -> sign 0, exp 5'b00100, mantissa 0x1F04, out_valid one cycle after the 4th bit.
REQ-037 Lane independence: lane1 act=0xF234 with the same bits and lane2 act=0x3C00 with bits 0,0,0,0 -> lane1 sign 1, exp 5'b11100, mantissa 0x1F04; lane2 mantissa 0, sign 0.
REQ-038 Signed weights (macro on): act=0x3C00, w_signed=1, precision=4, bits 1,1,1,1 (-1) -> sign 1, mantissa 0x400; with the macro off, the same stimulus gives sign 0, mantissa 0x3C00.
REQ-039 Backpressure: out_ready=0, two words streamed -> in_ready drops only on the second word's final beat, word 1 is held stable, and raising out_ready completes word 2 with no lost or duplicated output.
REQ-040 Pause and reset: a valid gap of 3 cycles mid-word gives an unchanged result, and rst low after 2 of 4 bits clears out_valid/outputs to 0, with the next full word correct.
REQ-041 Precision edges: precision=0 behaves as 8, and precision=1 with bit 1 gives mantissa = mant, with out_valid on the following cycle.

Source files
------------

// File: rtl/fp_int_mul_vec.sv
// fp_int_mul_vec: multi-lane FP16 x bit-serial integer multiplier.
// Each lane multiplies the FP16 activation mantissa (hidden bit included)
// by a weight that arrives MSB first, one bit per beat, and returns the
// product as sign / raw exponent / unnormalised magnitude.
// Define FP_INT_MUL_VEC_SIGNED_EN to add two's-complement weight support.
// Without it, w_signed is ignored and no subtract path is built.
module fp_int_mul_vec #(
    parameter  int LANES    = 4,
    parameter  int MAX_PREC = 8,
    localparam int MANT_W   = 11 + MAX_PREC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [16*LANES-1:0]       act,
    input  logic [LANES-1:0]          w,
    input  logic                      valid,
    output logic                      in_ready,
    input  logic [3:0]                precision,
    input  logic                      w_signed,
    output logic [LANES-1:0]          sign_out,
    output logic [5*LANES-1:0]        exp_out,
    output logic [MANT_W*LANES-1:0]   mantissa_out,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // One extra bit so a negative partial product keeps its sign.
    localparam int ACC_W = MANT_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state;
    logic [3:0]             count;
    logic [3:0]             prec_q;
    logic [16*LANES-1:0]    act_q;
    logic [ACC_W-1:0]       acc [LANES];

    logic                   first_beat;
    logic                   last_beat;
    logic                   beat;
    logic [3:0]             prec_in_eff;
    logic [16*LANES-1:0]    act_cur;

    logic [15:0]            lane_act [LANES];
    logic [ACC_W-1:0]       mant_ext [LANES];
    logic [ACC_W-1:0]       acc_next [LANES];
    logic [MANT_W-1:0]      acc_mag  [LANES];

`ifndef FP_INT_MUL_VEC_SIGNED_EN
    // Weights are always unsigned in this build; the mode pin has no effect.
    logic unused_w_signed;
    assign unused_w_signed = w_signed;
`endif

    // Out-of-range precision falls back to the widest weight.
    assign prec_in_eff = (precision == 4'd0 || precision > 4'(MAX_PREC))
                         ? 4'(MAX_PREC) : precision;

    // A word starts in IDLE; its own precision decides if it is also the last bit.
    assign first_beat = (state == IDLE);
    assign last_beat  = first_beat ? (prec_in_eff == 4'd1)
                                   : (count == prec_q - 4'd1);

    // Only the beat that would write the output registers waits for a drain.
    assign in_ready = !(out_valid && !out_ready) || !last_beat;
    assign beat     = valid && in_ready;

    // The first beat uses the live activation; later beats use the latched copy.
    assign act_cur = first_beat ? act : act_q;

    // Per-lane shift-and-add step and the magnitude of its result.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            // NOTE: every comb output gets a value on every path, so no latch is inferred.
            lane_act[i] = act_cur[16*i +: 16];
            mant_ext[i] = ACC_W'({|lane_act[i][14:10], lane_act[i][9:0]});
            if (first_beat) begin
                acc_next[i] = w[i] ? mant_ext[i] : '0;
`ifdef FP_INT_MUL_VEC_SIGNED_EN
                // The MSB of a two's-complement weight carries negative weight.
                if (w_signed) begin
                    acc_next[i] = w[i] ? -mant_ext[i] : '0;
                end
`endif
            end else begin
                acc_next[i] = (acc[i] << 1) + (w[i] ? mant_ext[i] : '0);
            end
            acc_mag[i] = MANT_W'(acc_next[i][ACC_W-1] ? -acc_next[i] : acc_next[i]);
        end
    end

    // Word sequencing: state, bit counter, latched operands and accumulators.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= 4'd0;
            prec_q <= 4'd0;
            act_q  <= '0;
            // NOTE: the accumulator array is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
        end else if (beat) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= acc_next[i];
            end
            if (first_beat) begin
                act_q  <= act;
                prec_q <= prec_in_eff;
            end
            if (last_beat) begin
                state <= IDLE;
                count <= 4'd0;
            end else begin
                state <= SHIFT;
                count <= count + 4'd1;
            end
        end
    end

    // Result registers: load on the final beat, hold until drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            sign_out     <= '0;
            exp_out      <= '0;
            mantissa_out <= '0;
        end else if (beat && last_beat) begin
            out_valid <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                sign_out[i]                       <= lane_act[i][15] ^ acc_next[i][ACC_W-1];
                exp_out[5*i +: 5]                 <= lane_act[i][14:10];
                mantissa_out[MANT_W*i +: MANT_W]  <= acc_mag[i];
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_int_mul_vec.sv
// Directed testbench for fp_int_mul_vec (LANES=4, MAX_PREC=8).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_fp_int_mul_vec;

    localparam int LANES    = 4;
    localparam int MAX_PREC = 8;
    localparam int MANT_W   = 11 + MAX_PREC;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [16*LANES-1:0]     act = '0;
    logic [LANES-1:0]        w = '0;
    logic                    valid = 1'b0;
    logic                    in_ready;
    logic [3:0]              precision = 4'd0;
    logic                    w_signed = 1'b0;
    logic [LANES-1:0]        sign_out;
    logic [5*LANES-1:0]      exp_out;
    logic [MANT_W*LANES-1:0] mantissa_out;
    logic                    out_valid;
    logic                    out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    fp_int_mul_vec #(.LANES(LANES), .MAX_PREC(MAX_PREC)) dut (
        .clk          (clk),
        .rst          (rst),
        .act          (act),
        .w            (w),
        .valid        (valid),
        .in_ready     (in_ready),
        .precision    (precision),
        .w_signed     (w_signed),
        .sign_out     (sign_out),
        .exp_out      (exp_out),
        .mantissa_out (mantissa_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [MANT_W-1:0] mant_of(input int i);
        return mantissa_out[MANT_W*i +: MANT_W];
    endfunction

    function automatic logic [4:0] exp_of(input int i);
        return exp_out[5*i +: 5];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One accepted bit beat, assuming in_ready is high.
    task automatic beat(input logic [LANES-1:0] wb);
        w     = wb;
        valid = 1'b1;
        cycle();
        valid = 1'b0;
        w     = '0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            failures++;
        end
        checks++;
        if (out_valid !== 1'b0 || sign_out !== '0 || exp_out !== '0 || mantissa_out !== '0) begin
            $display("FAIL reset_outputs: got valid=%b sign=%h exp=%h mant=%h expected all 0",
                     out_valid, sign_out, exp_out, mantissa_out);
            failures++;
        end
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
            failures++;
        end
    endtask

    task automatic test_unsigned();
        logic             es [LANES];
        logic [4:0]       ee [LANES];
        logic [MANT_W-1:0] em [LANES];
        es = '{1'b0, 1'b1, 1'b0, 1'b0};
        ee = '{5'b00100, 5'b11100, 5'b01111, 5'b00000};
        em = '{19'h1F04, 19'h1F04, 19'h0, 19'hF};
        out_ready = 1'b0;
        precision = 4'd4;
        w_signed  = 1'b0;
        // lane3 is a subnormal (hidden bit 0), lane2 gets an all-zero weight
        act = {16'h0003, 16'h3C00, 16'hF234, 16'h1234};
        beat(4'b0000);
        beat(4'b1011);
        beat(4'b0000);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL unsigned_early_valid: got %b expected 0", out_valid);
            failures++;
        end
        beat(4'b1011);
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL unsigned_latency: got out_valid=%b expected 1", out_valid);
            failures++;
        end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (sign_out[i] !== es[i] || exp_of(i) !== ee[i] || mant_of(i) !== em[i]) begin
                $display("FAIL unsigned_lane%0d: got sign=%b exp=%b mant=%h expected sign=%b exp=%b mant=%h",
                         i, sign_out[i], exp_of(i), mant_of(i), es[i], ee[i], em[i]);
                failures++;
            end
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL unsigned_drain: got out_valid=%b expected 0", out_valid);
            failures++;
        end
    endtask

    task automatic test_signed();
        logic             es [LANES];
        logic [MANT_W-1:0] em [LANES];
`ifdef FP_INT_MUL_VEC_SIGNED_EN
        es = '{1'b1, 1'b0, 1'b1, 1'b0};
        em = '{19'h400, 19'h1800, 19'h2000, 19'h400};
`else
        es = '{1'b0, 1'b0, 1'b0, 1'b1};
        em = '{19'h3C00, 19'h1800, 19'h2000, 19'h3C00};
`endif
        out_ready = 1'b1;
        precision = 4'd4;
        w_signed  = 1'b1;
        // weights: lane0 1111, lane1 0110, lane2 1000, lane3 1111
        act = {16'hBC00, 16'h3C00, 16'h3C00, 16'h3C00};
        beat(4'b1101);
        beat(4'b1011);
        beat(4'b1011);
        beat(4'b1001);
        w_signed = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (out_valid !== 1'b1 || sign_out[i] !== es[i] || exp_of(i) !== 5'b01111 || mant_of(i) !== em[i]) begin
                $display("FAIL signed_lane%0d: got valid=%b sign=%b exp=%b mant=%h expected 1 sign=%b exp=01111 mant=%h",
                         i, out_valid, sign_out[i], exp_of(i), mant_of(i), es[i], em[i]);
                failures++;
            end
        end
        cycle();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        precision = 4'd2;
        act = {48'h0, 16'h3C00};
        beat(4'b0001);
        beat(4'b0001);
        checks++;
        if (out_valid !== 1'b1 || mant_of(0) !== 19'hC00) begin
            $display("FAIL bp_word1: got valid=%b mant=%h expected 1 mant=00c00", out_valid, mant_of(0));
            failures++;
        end
        // word 2 first beat is not final, so it is accepted while word 1 waits
        act = {48'h0, 16'h4000};
        w = 4'b0001;
        valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_first_beat_ready: got %b expected 1", in_ready);
            failures++;
        end
        @(posedge clk);
        #1;
        // operand changes mid-word must be ignored
        act = {4{16'hFFFF}};
        precision = 4'd1;
        w = 4'b0000;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL bp_final_stall: got in_ready=%b expected 0", in_ready);
            failures++;
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || mant_of(0) !== 19'hC00 || exp_of(0) !== 5'b01111) begin
                $display("FAIL bp_hold%0d: got ready=%b valid=%b mant=%h exp=%b expected 0 1 00c00 01111",
                         k, in_ready, out_valid, mant_of(0), exp_of(0));
                failures++;
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
            failures++;
        end
        cycle();
        valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || mant_of(0) !== 19'h800 || exp_of(0) !== 5'b10000 || sign_out !== '0) begin
            $display("FAIL bp_word2: got valid=%b mant=%h exp=%b sign=%b expected 1 00800 10000 0000",
                     out_valid, mant_of(0), exp_of(0), sign_out);
            failures++;
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_no_duplicate: got out_valid=%b expected 0", out_valid);
            failures++;
        end
    endtask

    task automatic test_pause_reset();
        out_ready = 1'b1;
        precision = 4'd4;
        act = {48'h0, 16'h1234};
        beat(4'b0000);
        beat(4'b0001);
        act = {4{16'hFFFF}};
        for (int k = 0; k < 3; k++) cycle();
        beat(4'b0000);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL pause_early_valid: got %b expected 0", out_valid);
            failures++;
        end
        out_ready = 1'b0;
        beat(4'b0001);
        checks++;
        if (out_valid !== 1'b1 || mant_of(0) !== 19'h1F04 || exp_of(0) !== 5'b00100 || sign_out[0] !== 1'b0) begin
            $display("FAIL pause_result: got valid=%b mant=%h exp=%b sign=%b expected 1 01f04 00100 0",
                     out_valid, mant_of(0), exp_of(0), sign_out[0]);
            failures++;
        end
        // partial word, then asynchronous reset between edges
        act = {48'h0, 16'h3C00};
        beat(4'b0001);
        beat(4'b0001);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sign_out !== '0 || exp_out !== '0 || mantissa_out !== '0 || in_ready !== 1'b1) begin
            $display("FAIL midword_reset: got valid=%b sign=%h exp=%h mant=%h ready=%b expected 0 0 0 0 1",
                     out_valid, sign_out, exp_out, mantissa_out, in_ready);
            failures++;
        end
        cycle();
        rst = 1'b1;
        cycle();
        out_ready = 1'b1;
        beat(4'b0000);
        beat(4'b0000);
        beat(4'b0001);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL after_reset_early_valid: got %b expected 0", out_valid);
            failures++;
        end
        beat(4'b0001);
        checks++;
        if (out_valid !== 1'b1 || mant_of(0) !== 19'hC00 || exp_of(0) !== 5'b01111) begin
            $display("FAIL after_reset_word: got valid=%b mant=%h exp=%b expected 1 00c00 01111",
                     out_valid, mant_of(0), exp_of(0));
            failures++;
        end
        cycle();
    endtask

    task automatic test_precision();
        logic [7:0] bits;
        out_ready = 1'b1;
        // precision 0 behaves as 8 bits: 1000_0001 = 129
        precision = 4'd0;
        act = {48'h0, 16'h3C00};
        bits = 8'b1000_0001;
        for (int k = 7; k >= 0; k--) begin
            beat({3'b000, bits[k]});
            if (k != 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    $display("FAIL prec0_early_valid beat%0d: got %b expected 0", 8 - k, out_valid);
                    failures++;
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || mant_of(0) !== 19'h20400) begin
            $display("FAIL prec0_result: got valid=%b mant=%h expected 1 20400", out_valid, mant_of(0));
            failures++;
        end
        // precision above MAX_PREC, largest magnitude: 2047 * 255
        precision = 4'd15;
        act = {48'h0, 16'h07FF};
        for (int k = 0; k < 8; k++) beat(4'b0001);
        checks++;
        if (out_valid !== 1'b1 || mant_of(0) !== 19'h7F701 || exp_of(0) !== 5'b00001) begin
            $display("FAIL prec15_result: got valid=%b mant=%h exp=%b expected 1 7f701 00001",
                     out_valid, mant_of(0), exp_of(0));
            failures++;
        end
        // precision 1: one-beat words, back to back with no bubble
        precision = 4'd1;
        act = {48'h0, 16'h1234};
        beat(4'b0001);
        checks++;
        if (out_valid !== 1'b1 || mant_of(0) !== 19'h634 || exp_of(0) !== 5'b00100) begin
            $display("FAIL prec1_word_a: got valid=%b mant=%h exp=%b expected 1 00634 00100",
                     out_valid, mant_of(0), exp_of(0));
            failures++;
        end
        act = {48'h0, 16'h4000};
        beat(4'b0001);
        checks++;
        if (out_valid !== 1'b1 || mant_of(0) !== 19'h400 || exp_of(0) !== 5'b10000) begin
            $display("FAIL back_to_back_word_b: got valid=%b mant=%h exp=%b expected 1 00400 10000",
                     out_valid, mant_of(0), exp_of(0));
            failures++;
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL back_to_back_drain: got out_valid=%b expected 0", out_valid);
            failures++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_pressure();
        test_pause_reset();
        test_precision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
